// File: rtl/prio_encoder_rr.sv
// Round-robin priority encoder: latches request pulses and presents one granted
// index at a time through a valid/ready handshake, rotating priority after each grant.
module prio_encoder_rr #(
  parameter int unsigned N = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [(2**N)-1:0]   req,
  input  logic                en,
  input  logic                out_ready,
  output logic [N-1:0]        out_idx,
  output logic                out_valid,
  output logic [(2**N)-1:0]   pending
);

  localparam int unsigned W = 2**N;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_idx_q, out_idx_d;
  logic [W-1:0]   pending_q, pending_d;
  logic [N-1:0]   last_q, last_d;

  logic           hs_c;
  logic           start_c;
  logic           rr_found_c;
  logic [N-1:0]   rr_idx_c;
  logic [W-1:0]   clr_mask_c;

  // State register; reset leaves last at the top index so the first search starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      pending_q   <= '0;
      last_q      <= '1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      pending_q   <= pending_d;
      last_q      <= last_d;
    end
  end

  // First set pending bit in the order last+1, last+2, ... wrapping back to last.
  always_comb begin
    rr_found_c = 1'b0;
    rr_idx_c   = '0;
    for (int unsigned i = 1; i <= W; i++) begin
      logic [N-1:0] cand;
      cand = last_q + N'(i);
      if (!rr_found_c && pending_q[cand]) begin
        rr_found_c = 1'b1;
        rr_idx_c   = cand;
      end
    end
  end

  assign hs_c    = (state_q == PRESENT) && out_ready;
  assign start_c = (state_q == IDLE) && en && rr_found_c;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_c) state_d = PRESENT;
      PRESENT: if (hs_c)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: new requests are OR-ed in after the served bit is cleared, so a set wins.
  always_comb begin
    clr_mask_c  = '0;
    out_idx_d   = out_idx_q;
    last_d      = last_q;
    if (hs_c) begin
      clr_mask_c = W'(1) << out_idx_q;
      last_d     = out_idx_q;
    end
    if (start_c) begin
      out_idx_d = rr_idx_c;
    end
    pending_d   = (pending_q & ~clr_mask_c) | req;
    out_valid_d = (state_d == PRESENT);
  end

  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr (N=3): single grant, full rotation, wrap,
// backpressure, set-wins collision, reset mid-grant and enable gating.
module tb_prio_encoder_rr;

  localparam int unsigned N = 3;
  localparam int unsigned W = 2**N;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] req;
  logic         en;
  logic         out_ready;
  logic [N-1:0] out_idx;
  logic         out_valid;
  logic [W-1:0] pending;

  int n_vec;
  int n_err;

  prio_encoder_rr #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .en        (en),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] exp_pend;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req       = '0;
    en        = 1'b0;
    out_ready = 1'b0;
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_idx",   32'(out_idx),   32'd0);
    check("rst_pend",  32'(pending),   32'd0);
    cyc();
    rst_n = 1'b1;

    // Single request at index 4.
    en = 1'b1; out_ready = 1'b1; req = 8'b0001_0000;
    cyc();
    check("single_latch_pend",  32'(pending),   32'h10);
    check("single_latch_valid", 32'(out_valid), 32'd0);
    req = '0;
    cyc();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_idx",   32'(out_idx),   32'd4);
    cyc();
    check("single_done_valid", 32'(out_valid), 32'd0);
    check("single_done_pend",  32'(pending),   32'd0);

    // Full rotation starting from index 0 after reset.
    do_reset();
    req = 8'hFF;
    cyc();
    check("rr_latch", 32'(pending), 32'hFF);
    req = '0;
    exp_pend = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_idx",   32'(out_idx),   32'(k));
      cyc();
      exp_pend[k] = 1'b0;
      check("rr_bubble", 32'(out_valid), 32'd0);
      check("rr_pend",   32'(pending),   32'(exp_pend));
    end

    // Wrap-around: after serving 6, bits 1 and 7 give 7 then 1.
    do_reset();
    req = 8'h40;
    cyc();
    req = '0;
    cyc();
    check("wrap_idx6", 32'(out_idx), 32'd6);
    cyc();
    check("wrap_hs6", 32'(out_valid), 32'd0);
    req = 8'h82;
    cyc();
    check("wrap_pend", 32'(pending), 32'h82);
    req = '0;
    cyc();
    check("wrap_valid7", 32'(out_valid), 32'd1);
    check("wrap_idx7",   32'(out_idx),   32'd7);
    cyc();
    check("wrap_pend_after7", 32'(pending), 32'h02);
    cyc();
    check("wrap_idx1", 32'(out_idx), 32'd1);
    cyc();
    check("wrap_done", 32'(pending), 32'd0);

    // Backpressure on index 2 with en dropped while presenting.
    do_reset();
    out_ready = 1'b0; req = 8'h04;
    cyc();
    req = '0;
    cyc();
    check("bp_idx", 32'(out_idx), 32'd2);
    req = 8'h01; en = 1'b0;
    cyc();
    check("bp_pend0", 32'(pending), 32'h05);
    req = '0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("bp_hold_idx",   32'(out_idx),   32'd2);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_pend",  32'(pending),   32'h05);
    end
    out_ready = 1'b1; en = 1'b1;
    cyc();
    check("bp_hs_valid", 32'(out_valid), 32'd0);
    check("bp_hs_pend",  32'(pending),   32'h01);
    cyc();
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_idx",   32'(out_idx),   32'd0);
    cyc();
    check("bp_done", 32'(pending), 32'd0);

    // Set wins over the handshake clear on index 3.
    do_reset();
    req = 8'h08;
    cyc();
    req = '0;
    cyc();
    check("sw_idx", 32'(out_idx), 32'd3);
    req = 8'h08;
    cyc();
    check("sw_hs_valid", 32'(out_valid), 32'd0);
    check("sw_hs_pend",  32'(pending),   32'h08);
    req = '0;
    cyc();
    check("sw_regrant_valid", 32'(out_valid), 32'd1);
    check("sw_regrant_idx",   32'(out_idx),   32'd3);
    cyc();
    check("sw_done", 32'(pending), 32'd0);

    // Reset mid-grant, then enable gating.
    do_reset();
    req = 8'h20;
    cyc();
    req = 8'h01;
    cyc();
    check("mr_valid", 32'(out_valid), 32'd1);
    check("mr_idx",   32'(out_idx),   32'd5);
    req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_rst_valid", 32'(out_valid), 32'd0);
    check("mr_rst_pend",  32'(pending),   32'd0);
    check("mr_rst_idx",   32'(out_idx),   32'd0);
    cyc();
    rst_n = 1'b1; en = 1'b0; req = 8'h01;
    cyc();
    check("gate_pend", 32'(pending), 32'h01);
    req = '0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      check("gate_valid", 32'(out_valid), 32'd0);
      check("gate_pend_hold", 32'(pending), 32'h01);
    end
    en = 1'b1;
    cyc();
    check("gate_en_valid", 32'(out_valid), 32'd1);
    check("gate_en_idx",   32'(out_idx),   32'd0);
    cyc();
    check("gate_done", 32'(pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
